l2todr_req_fifo: RTL
====================

// Module: l2todr_req_fifo
// PURPOSE
//  Elastic valid/retry request queue between the L2-to-directory arbiter's
//  l2todr_req output and the directory request input. Decouples arbiter
//  grant timing from directory back-pressure. Also exports occupancy and
//  stall statistics for perf counters. Strict FIFO order, payload opaque.
// PARAMETERS
//  WIDTH   64  payload bits; instantiated with $bits(I_l2todr_req_type)
//  DEPTH   4   entries; power of 2, >= 2
//  CNTW    16  width of stall counter
// PORTS
//  clk            in   1          clock, all state on posedge
//  reset          in   1          synchronous, active-high
//  in_valid       in   1          upstream request valid (arbiter l2todr_req_valid)
//  in_retry       out  1          back-pressure to upstream
//  in_data        in   WIDTH      upstream request payload
//  out_valid      out  1          request valid toward directory
//  out_retry      in   1          directory back-pressure
//  out_data       out  WIDTH      head-of-queue payload
//  occupancy      out  clog2(DEPTH+1)  current entries
//  high_water     out  clog2(DEPTH+1)  max occupancy since reset
//  stall_cnt      out  CNTW       cycles with out_valid && out_retry
// BEHAVIOUR
//  - Single clock domain (clk). reset is synchronous and active-high.
//  - Reset: occupancy=0, high_water=0, stall_cnt=0, out_valid=0, in_retry=0;
//    pointers=0; out_data don't-care (RAM not cleared).
//  - Handshake: transfer on a port when valid && !retry in the same cycle.
//    push = in_valid && !in_retry; pop = out_valid && !out_retry.
//  - in_retry = (occupancy == DEPTH), driven from registered state only.
//    No combinational path from out_retry to in_retry: full queue refuses
//    push even if a pop occurs that cycle.
//  - out_valid = (occupancy != 0), out_data = mem[rd_ptr]; both registered.
//    No bypass: minimum latency in_valid -> out_valid is 1 cycle.
//  - out_valid, once high, stays high and out_data stays stable until pop.
//  - Pointers log2(DEPTH) bits, wrap modulo DEPTH; wr_ptr++ on push,
//    rd_ptr++ on pop.
//  - occupancy next = occupancy + push - pop; push&&pop leaves it unchanged.
//  - Empty + push: entry visible next cycle; no pop same cycle.
//  - high_water updates to occupancy_next if greater; never decreases
//    except on reset.
//  - stall_cnt increments each cycle out_valid && out_retry; saturates at
//    2^CNTW-1 without wrap.
//  - in_valid while in_retry: no write, no state change; upstream must hold
//    its request, but this block does not depend on data stability.
//  - reset mid-operation: all queued entries dropped; next cycle the queue
//    is empty with in_retry=0.
//  - Assertions (sim only): occupancy <= DEPTH; no pop when empty; no push
//    when full.
// TESTING
//  1 reset, in_valid=1 data=0xA1 one cycle, out_retry=0 -> out_valid=1 next
//    cycle with out_data=0xA1; pop; occupancy back to 0; high_water=1.
//  2 out_retry=1, push 0x10..0x13 (DEPTH=4) -> in_retry=1 after 4th push;
//    5th in_valid refused, occupancy=4, stall_cnt counts every
//    out_valid && out_retry cycle.
//  3 full, release out_retry with in_valid=1 same cycle -> pop 0x10, push
//    refused that cycle; next cycle in_retry=0 and push accepted; output
//    order 0x10,0x11,0x12,0x13,new.
//  4 occupancy=2, push and pop every cycle for 20 cycles -> occupancy
//    stays 2, pointers wrap 5 times, output order == input order.
//  5 occupancy=3, reset=1 one cycle -> next cycle out_valid=0, in_retry=0,
//    occupancy=0, high_water=0, stall_cnt=0; no stale entry emerges later.
//  6 CNTW=4, hold out_valid with out_retry=1 for 20 cycles -> stall_cnt
//    saturates at 15.

Source files
------------

// File: rtl/l2todr_req_fifo_if.sv
// Valid/retry request channel for the L2-to-directory request queue.
// The upstream (arbiter) side and the downstream (directory) side share one
// bundle; the queue itself connects through the slave modport.
interface l2todr_req_fifo_if #(
  parameter int unsigned WIDTH = 64
) ();
  logic             in_valid;
  logic             in_retry;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_retry;
  logic [WIDTH-1:0] out_data;

  // Queue side: accepts requests, presents the head toward the directory.
  modport slave (
    input  in_valid, in_data, out_retry,
    output in_retry, out_valid, out_data
  );

  // Environment side: arbiter drives requests, directory drives back-pressure.
  modport master (
    output in_valid, in_data, out_retry,
    input  in_retry, out_valid, out_data
  );
endinterface

// File: rtl/l2todr_req_fifo.sv
// Elastic valid/retry queue between the L2-to-directory arbiter and the
// directory request input. Strict FIFO order, opaque payload, no bypass.
// Exports occupancy, high-water mark and a saturating stall counter.
module l2todr_req_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  l2todr_req_fifo_if.slave                 bus,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy,
  output logic [$clog2(DEPTH+1)-1:0]       high_water,
  output logic [CNTW-1:0]                  stall_cnt
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [OW-1:0]    r_occ;
  logic [OW-1:0]    r_hw;
  logic [CNTW-1:0]  r_stall;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [OW-1:0]    w_occ_next;

  // Handshake decode; full/empty come from registered occupancy only, so a
  // full queue refuses a push even when the head pops in the same cycle.
  always_comb begin
    w_full     = (r_occ == OW'(DEPTH));
    w_empty    = (r_occ == '0);
    w_push     = bus.in_valid && !w_full;
    w_pop      = !w_empty && !bus.out_retry;
    w_occ_next = r_occ + OW'(w_push) - OW'(w_pop);
  end

  assign bus.in_retry  = w_full;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = r_mem[r_rd_ptr];
  assign occupancy     = r_occ;
  assign high_water    = r_hw;
  assign stall_cnt     = r_stall;

  // Payload storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // Pointers, occupancy and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_hw     <= '0;
      r_stall  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_occ <= w_occ_next;
      if (w_occ_next > r_hw) r_hw <= w_occ_next;
      if (!w_empty && bus.out_retry && (r_stall != '1)) begin
        r_stall <= r_stall + CNTW'(1);
      end
    end
  end

  // Structural invariants of the queue.
  a_occ_range: assert property (@(posedge clk) disable iff (reset)
    r_occ <= OW'(DEPTH));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
    w_pop |-> !w_empty);
  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    w_push |-> !w_full);
endmodule
